ram_nport: RTL and testbench

Parametrised synchronous RAM with one write port and N independent read ports, the next-generation replacement for fixed 16x8 register-file memories in lab datapaths. Adds registered reads with valid flags, a hardware clear sequencer (runs automatically after reset and on request), and optional write-to-read bypass. Sits between the datapath and any block that needs multiple simultaneous operand reads, such as register files and lookup tables.

---
 rtl/ram_nport_pkg.sv | 17 +
 rtl/ram_clear_fsm.sv | 64 ++++++
 rtl/ram_nport.sv | 102 ++++++++++
 tb/tb_ram_nport.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ram_nport_pkg.sv
// Shared types and helpers for the N-read-port RAM and its clear sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_nport_pkg;

  // Clear sequencer states: sweeping the array, or serving user traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

  // Number of words addressed by an addr_w-bit address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: sweeps CLEAR_VAL over every word after reset and on clr request.
// Latency: busy rises the cycle after clr is sampled; the sweep lasts DEPTH cycles.
// Backpressure: none; while busy the RAM ignores user writes, reads and clr.
module ram_clear_fsm
  import ram_nport_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam int DEPTH = depth_of(ADDR_W);
  // Completion is detected on the last address, not on pointer wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  // Next-state: advance the sweep pointer, or arm a new sweep on clr.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State, pointer and busy registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign busy     = busy_q;

endmodule

// File: rtl/ram_nport.sv
// One-write / RD_PORTS-read synchronous RAM with hardware clear sequencer.
// Latency: 1 cycle for reads (dout/rvalid registered); writes visible the next cycle.
// Backpressure: none; busy=1 during clear, when we/re/clr are ignored.
// Build option: define RAM_NPORT_BYPASS_EN for write-first collisions (default read-first).
module ram_nport
  import ram_nport_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter int                RD_PORTS  = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            din,
  input  logic [RD_PORTS-1:0]          re,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   dout,
  output logic [RD_PORTS-1:0]          rvalid,
  input  logic                         clr,
  output logic                         busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdat;

  ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Write mux: the clear sweep owns the write port; user writes only when idle.
  always_comb begin
    user_we   = we & ~busy;
    mem_we    = clr_we | user_we;
    mem_waddr = waddr;
    mem_wdat  = din;
    if (clr_we) begin
      mem_waddr = clr_addr;
      mem_wdat  = CLEAR_VAL;
    end
  end

  // Storage array; contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rd_en;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rvalid_q, rvalid_d;

    // Read port: capture on re, otherwise hold data and drop valid.
    always_comb begin
      ra       = raddr[i*ADDR_W +: ADDR_W];
      rd_en    = re[i] & ~busy;
      rvalid_d = rd_en;
      dout_d   = dout_q;
      if (rd_en) begin
        dout_d = mem_q[ra];
`ifdef RAM_NPORT_BYPASS_EN
        if (user_we && (waddr == ra)) begin
          dout_d = din;
        end
`endif
      end
    end

    // Registered read data and valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign dout[i*DATA_W +: DATA_W] = dout_q;
    assign rvalid[i]                = rvalid_q;
  end

endmodule

// File: tb/tb_ram_nport.sv
// Directed bench for ram_nport: default 2-port instance plus a 4-port/64x16 instance.
// Inputs change and outputs are sampled on the falling clock edge.
// Collision expectation follows the RAM_NPORT_BYPASS_EN build option.
module tb_ram_nport;

`ifdef RAM_NPORT_BYPASS_EN
  localparam logic [7:0] EXP_COL = 8'h5A;
`else
  localparam logic [7:0] EXP_COL = 8'h11;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [7:0]  din;
  logic [1:0]  re;
  logic [7:0]  raddr;
  logic [15:0] dout;
  logic [1:0]  rvalid;
  logic        clr;
  logic        busy;

  logic        we4;
  logic [5:0]  waddr4;
  logic [15:0] din4;
  logic [3:0]  re4;
  logic [23:0] raddr4;
  logic [63:0] dout4;
  logic [3:0]  rvalid4;
  logic        clr4;
  logic        busy4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_nport dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .din(din), .re(re),
    .raddr(raddr), .dout(dout), .rvalid(rvalid), .clr(clr), .busy(busy)
  );

  ram_nport #(.DATA_W(16), .ADDR_W(6), .RD_PORTS(4)) dut4 (
    .clk(clk), .rst(rst), .we(we4), .waddr(waddr4), .din(din4), .re(re4),
    .raddr(raddr4), .dout(dout4), .rvalid(rvalid4), .clr(clr4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; waddr = 4'(a); din = 8'(d);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd2(input int a0, input int a1);
    re = 2'b11; raddr = {4'(a1), 4'(a0)};
    @(negedge clk);
    re = 2'b00;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; we = 1'b0; waddr = '0; din = '0; re = '0; raddr = '0; clr = 1'b0;
    we4 = 1'b0; waddr4 = '0; din4 = '0; re4 = '0; raddr4 = '0; clr4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);

    // Power-on sweep and read-back of zeros on both ports.
    rst = 1'b0;
    count_busy(n);
    chk("por_busy_cycles", 64'(n), 64'd16);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      rd2(a, 15 - a);
      if ({rvalid, dout} !== 18'h30000) bad++;
    end
    chk("por_read_zero_bad", 64'(bad), 64'd0);

    // Write then read the same address on both ports next cycle.
    wr(3, 'hA5);
    rd2(3, 3);
    chk("wr_rd_rvalid", 64'(rvalid), 64'd3);
    chk("wr_rd_dout", 64'(dout), 64'hA5A5);
    @(negedge clk);
    chk("idle_rvalid_drop", 64'(rvalid), 64'd0);
    chk("idle_dout_hold", 64'(dout), 64'hA5A5);

    // Same-cycle write/read collision on port 0.
    wr(7, 'h11);
    we = 1'b1; waddr = 4'd7; din = 8'h5A; re = 2'b01; raddr = {4'd0, 4'd7};
    @(negedge clk);
    we = 1'b0; re = 2'b00;
    chk("collide_rvalid", 64'(rvalid), 64'd1);
    chk("collide_dout0", 64'(dout[7:0]), 64'(EXP_COL));
    rd2(7, 3);
    chk("post_collide", 64'(dout), 64'hA55A);

    // Fill with 0xFF, then a distinctive word so held data is recognisable.
    for (int a = 0; a < 16; a++) wr(a, 'hFF);
    rd2(0, 15);
    chk("fill_ff", 64'(dout), 64'hFFFF);
    wr(1, 'h42);
    rd2(1, 1);
    chk("pre_clr_dout", 64'(dout), 64'h4242);

    // One-cycle clr pulse; writes and reads attempted during the sweep are ignored.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      n++;
      we = 1'b1; waddr = 4'd5; din = 8'h33; re = 2'b11; raddr = {4'd5, 4'd5};
      @(negedge clk);
      if (rvalid !== 2'b00) bad++;
    end
    we = 1'b0; re = 2'b00;
    chk("clr_busy_cycles", 64'(n), 64'd16);
    chk("clr_rvalid_low_bad", 64'(bad), 64'd0);
    chk("clr_dout_hold", 64'(dout), 64'h4242);
    rd2(5, 1);
    chk("clr_ignored_write", 64'(dout), 64'h0000);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      rd2(a, a);
      if ({rvalid, dout} !== 18'h30000) bad++;
    end
    chk("clr_read_zero_bad", 64'(bad), 64'd0);

    // Reset at clear cycle 8 restarts a full sweep.
    wr(2, 'h77);
    rd2(2, 2);
    chk("pre_rst_dout", 64'(dout), 64'h7777);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_clr_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd1);
    chk("mid_rst_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    count_busy(n);
    chk("mid_rst_busy_cycles", 64'(n), 64'd16);
    rd2(2, 15);
    chk("mid_rst_read", 64'({rvalid, dout}), 64'h30000);

    // Wide instance: four ports read four distinct addresses at once.
    n = 0;
    while (busy4 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("w4_busy_done", 64'(busy4), 64'd0);
    for (int k = 0; k < 4; k++) begin
      we4 = 1'b1; waddr4 = 6'(k * 21); din4 = 16'(16'h1000 + k * 21);
      @(negedge clk);
    end
    we4 = 1'b0;
    re4 = 4'hF; raddr4 = {6'd63, 6'd42, 6'd21, 6'd0};
    @(negedge clk);
    re4 = 4'h0;
    chk("w4_rvalid", 64'(rvalid4), 64'hF);
    chk("w4_dout", dout4, 64'h103F_102A_1015_1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
